// File: rtl/midi_pkg.sv
// Shared MIDI transmit definitions: bit timing default, status nibbles,
// message-length decode and the state encodings of the serializer and sequencer.
package midi_pkg;

   localparam int MIDI_CLKS_PER_BIT = 1600;

   localparam logic [3:0] NOTE_OFF    = 4'h8;
   localparam logic [3:0] NOTE_ON     = 4'h9;
   localparam logic [3:0] POLY_AT     = 4'hA;
   localparam logic [3:0] CTRL_CHANGE = 4'hB;
   localparam logic [3:0] PROG_CHANGE = 4'hC;
   localparam logic [3:0] CHAN_AT     = 4'hD;
   localparam logic [3:0] PITCH_BEND  = 4'hE;
   localparam logic [3:0] SYSTEM      = 4'hF;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {SEQ_IDLE, SEQ_SEND, SEQ_DONE} seq_state_e;

   // Total bytes of a message including its status byte.
   function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
      logic [1:0] len;
      case (status[7:4])
         PROG_CHANGE, CHAN_AT: len = 2'd2;
         SYSTEM: begin
            case (status[3:0])
               4'h1, 4'h3: len = 2'd2;
               4'h2:       len = 2'd3;
               default:    len = 2'd1;
            endcase
         end
         default: len = 2'd3;
      endcase
      return len;
   endfunction

   function automatic logic is_channel_status(input logic [7:0] status);
      return status[7] && (status[7:4] != SYSTEM);
   endfunction

endpackage

// File: rtl/midi_uart_tx_byte.sv
// 8N1 byte serializer. A new byte can be taken on the closing edge of the
// stop bit so consecutive bytes go out with no idle gap.
module midi_uart_tx_byte
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       byte_done,
   output logic       tx
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

   tx_state_e  state;
   logic [TW-1:0] timer;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic       bit_end;

   assign bit_end    = (timer == T_LAST);
   assign byte_done  = (state == TX_STOP) && bit_end;
   assign byte_ready = (state == TX_IDLE) || byte_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= TX_IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         timer <= (state == TX_IDLE || bit_end) ? '0 : timer + 1'b1;
         case (state)
            TX_IDLE: begin
               if (byte_valid) begin
                  shreg <= byte_data;
                  tx    <= 1'b0;
                  state <= TX_START;
               end
            end
            TX_START: begin
               if (bit_end) begin
                  tx      <= shreg[0];
                  bit_idx <= '0;
                  state   <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (bit_end) begin
                  // shreg[0] is always the bit on the line; shift to expose the next
                  shreg   <= {1'b0, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= TX_STOP;
                  end else begin
                     tx <= shreg[1];
                  end
               end
            end
            TX_STOP: begin
               if (bit_end) begin
                  if (byte_valid) begin
                     shreg <= byte_data;
                     tx    <= 1'b0;
                     state <= TX_START;
                  end else begin
                     tx    <= 1'b1;
                     state <= TX_IDLE;
                  end
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/midi_transmitter.sv
// MIDI OUT: takes one message per handshake, decodes its length, applies
// running status and feeds the bytes back-to-back to the UART serializer.
module midi_transmitter
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT   = MIDI_CLKS_PER_BIT,
   parameter bit RUNNING_STATUS = 1'b1
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       msg_valid,
   output logic       msg_ready,
   input  logic [7:0] msg_status,
   input  logic [6:0] msg_data1,
   input  logic [6:0] msg_data2,
   output logic       MIDI_TX,
   output logic       busy,
   output logic       msg_done,
   output logic       msg_error
);

   seq_state_e      state;
   logic [7:0]      last_status;
   logic            last_valid;
   logic [2:0][7:0] bytes_q;
   logic [1:0]      nbytes_q;
   logic [1:0]      byte_idx;

   logic            accept;
   logic            skip;
   logic            more;
   logic [1:0]      len;
   logic [2:0][7:0] msg_bytes;
   logic            byte_valid;
   logic [7:0]      byte_data;
   logic            byte_ready;
   logic            byte_done;

   assign accept = (state == SEQ_IDLE) && msg_valid && msg_ready && byte_ready;
   assign len    = midi_msg_len(msg_status);
   assign skip   = RUNNING_STATUS && is_channel_status(msg_status) && last_valid &&
                   (msg_status == last_status);
   assign more   = ({1'b0, byte_idx} + 3'd1) < {1'b0, nbytes_q};

   // Byte 0 is the first on the wire; a skipped status shifts the data bytes down.
   always_comb begin
      if (skip) msg_bytes = {8'h00, {1'b0, msg_data2}, {1'b0, msg_data1}};
      else      msg_bytes = {{1'b0, msg_data2}, {1'b0, msg_data1}, msg_status};
   end

   // The first byte is handed over on the accept edge so the start bit begins
   // on the very next cycle; later bytes are handed over at each stop-bit end.
   always_comb begin
      byte_valid = 1'b0;
      byte_data  = msg_bytes[0];
      if (state == SEQ_IDLE) begin
         byte_valid = accept && msg_status[7];
      end else if (state == SEQ_SEND) begin
         byte_valid = byte_done && more;
         byte_data  = bytes_q[byte_idx + 2'd1];
      end
   end

   midi_uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk       (CLOCK_50),
      .rst       (RESET),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_ready(byte_ready),
      .byte_done (byte_done),
      .tx        (MIDI_TX)
   );

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state       <= SEQ_IDLE;
         msg_ready   <= 1'b1;
         busy        <= 1'b0;
         msg_done    <= 1'b0;
         msg_error   <= 1'b0;
         last_status <= '0;
         last_valid  <= 1'b0;
         bytes_q     <= '0;
         nbytes_q    <= '0;
         byte_idx    <= '0;
      end else begin
         msg_done  <= 1'b0;
         msg_error <= 1'b0;
         case (state)
            SEQ_IDLE: begin
               if (accept) begin
                  if (!msg_status[7]) begin
                     msg_error <= 1'b1;
                  end else begin
                     bytes_q   <= msg_bytes;
                     nbytes_q  <= len - {1'b0, skip};
                     byte_idx  <= '0;
                     state     <= SEQ_SEND;
                     msg_ready <= 1'b0;
                     busy      <= 1'b1;
                     // Real-time F8-FF must not disturb running status.
                     if (is_channel_status(msg_status)) begin
                        last_status <= msg_status;
                        last_valid  <= 1'b1;
                     end else if (msg_status[7:3] == 5'b11110) begin
                        last_valid <= 1'b0;
                     end
                  end
               end
            end
            SEQ_SEND: begin
               if (byte_done) begin
                  if (more) begin
                     byte_idx <= byte_idx + 2'd1;
                  end else begin
                     state    <= SEQ_DONE;
                     msg_done <= 1'b1;
                  end
               end
            end
            SEQ_DONE: begin
               state     <= SEQ_IDLE;
               msg_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= SEQ_IDLE;
         endcase
      end
   end

endmodule
